// File: rtl/altr_hps_scan_pkg.sv
// Shared definitions for the HPS scan chain controller: FSM state encoding.
package altr_hps_scan_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/altr_hps_scan_shreg.sv
// Serial-in capture register plus parallel-in/serial-out load register
// for one scan pass; the top level sequences load, shift and clear.
module altr_hps_scan_shreg #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear,
  input  logic [CHAIN_LEN-2:0] load_bits,
  input  logic                 so_in,
  output logic                 next_bit,
  output logic [CHAIN_LEN-1:0] cap_data
);

  // Bit 0 of the write word is driven straight into chain_si at acceptance,
  // so only the remaining bits are held here; pend_q[0] is always the next one.
  logic [CHAIN_LEN-2:0] pend_q, pend_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;

  always_comb begin
    pend_d = pend_q;
    cap_d  = cap_q;
    if (load) begin
      pend_d = load_bits;
    end else if (shift) begin
      pend_d = pend_q >> 1;
    end
    if (clear) begin
      cap_d = '0;
    end else if (shift) begin
      cap_d = {so_in, cap_q[CHAIN_LEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cap_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cap_q  <= cap_d;
    end
  end

  assign next_bit = pend_q[0];
  assign cap_data = cap_q;

endmodule

// File: rtl/altr_hps_scan_chain_ctrl.sv
// Scan chain access controller: one request unloads the chain into rsp_rdata
// while loading req_wdata, using a CHAIN_LEN-cycle scan-enable window.
module altr_hps_scan_chain_ctrl
  import altr_hps_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAIN_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 chain_scanen,
  output logic                 chain_si,
  input  logic                 chain_so
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             scanen_q, scanen_d;
  logic             si_q, si_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             accept;
  logic             shifting;
  logic             next_bit;

  assign accept   = (state_q == ST_IDLE) & req_valid & req_ready_q;
  assign shifting = (state_q == ST_SHIFT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    scanen_d    = scanen_q;
    si_d        = si_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SHIFT;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          scanen_d    = 1'b1;
          si_d        = req_wdata[0];
        end
      end
      ST_SHIFT: begin
        // Falling out of SHIFT always passes through RESP and IDLE, which
        // guarantees a scan-enable low gap between consecutive passes.
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_RESP;
          scanen_d    = 1'b0;
          si_d        = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          si_d  = next_bit;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        scanen_d    = 1'b0;
        si_d        = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      scanen_q    <= 1'b0;
      si_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      scanen_q    <= scanen_d;
      si_q        <= si_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  altr_hps_scan_shreg #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shifting),
    .clear    (accept),
    .load_bits(req_wdata[CHAIN_LEN-1:1]),
    .so_in    (chain_so),
    .next_bit (next_bit),
    .cap_data (rsp_rdata)
  );

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign chain_scanen = scanen_q;
  assign chain_si     = si_q;

endmodule
